// File: rtl/irrigation_bus_pkg.sv
// Shared types and constants for the irrigation peripheral-bus master.
package irrigation_bus_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] DEF_EC_ADDR   = 5'h04;
    localparam logic [ADDR_W-1:0] DEF_GPIO_ADDR = 5'h00;

    localparam int VALVE_BIT = 0;
    localparam int ALARM_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DECIDE,
        ST_WR,
        ST_WAIT
    } state_t;

    // Valve has hysteresis between low and high; the alarm has none.
    function automatic logic [1:0] decide_cmd(
        input logic [15:0] ec,
        input logic [1:0]  prev,
        input logic [15:0] low,
        input logic [15:0] high,
        input logic [15:0] alarm
    );
        logic [1:0] cmd;
        cmd = prev;
        if (ec < low) begin
            cmd[VALVE_BIT] = 1'b1;
        end else if (ec > high) begin
            cmd[VALVE_BIT] = 1'b0;
        end
        cmd[ALARM_BIT] = (ec >= alarm);
        return cmd;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Down-counter that flags the last allowed wait cycle of a bus transaction.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(TIMEOUT_CYCLES);
        end else if (tick && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/irrigation_bus_master.sv
// Polls the conductivity register, applies valve/alarm hysteresis and writes
// the command to GPIO over the shared peripheral bus.
//
// state  | meaning
// IDLE   | bus idle, waiting for enable
// RD     | first cycle launches the read strobes, then waits for ready
// DECIDE | computes valve/alarm and launches the GPIO write
// WR     | waits for write ready
// WAIT   | period down-count between polls
module irrigation_bus_master
    import irrigation_bus_pkg::*;
#(
    parameter int                PERIOD_CYCLES  = 1000,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [ADDR_W-1:0] EC_ADDR        = DEF_EC_ADDR,
    parameter logic [ADDR_W-1:0] GPIO_ADDR      = DEF_GPIO_ADDR,
    parameter logic [15:0]       EC_LOW         = 16'd300,
    parameter logic [15:0]       EC_HIGH        = 16'd600,
    parameter logic [15:0]       EC_ALARM       = 16'd900
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_cs,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic [15:0]       ec_value,
    output logic [1:0]        valve_cmd,
    output logic              busy,
    output logic              timeout_err
);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);

    state_t        state;
    logic [PW-1:0] period_cnt;
    logic [1:0]    next_cmd;
    logic          tmo_load;
    logic          tmo_tick;
    logic          tmo_clear;
    logic          tmo_expired;
    logic          unused_rdata_hi;

    assign unused_rdata_hi = ^bus_rdata[DATA_W-1:16];

    assign next_cmd = decide_cmd(ec_value, valve_cmd, EC_LOW, EC_HIGH, EC_ALARM);
    assign busy     = (state == ST_RD) || (state == ST_DECIDE) || (state == ST_WR);

    // Ready only counts while a strobe is actually on the bus.
    assign tmo_load  = ((state == ST_RD) && !bus_cs) || (state == ST_DECIDE);
    assign tmo_tick  = ((state == ST_RD) || (state == ST_WR)) && bus_cs && !bus_ready;
    assign tmo_clear = bus_cs && bus_ready;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (tmo_load),
        .tick   (tmo_tick),
        .clear  (tmo_clear),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            period_cnt  <= '0;
            bus_addr    <= '0;
            bus_cs      <= 1'b0;
            bus_rd      <= 1'b0;
            bus_wr      <= 1'b0;
            bus_wdata   <= '0;
            ec_value    <= '0;
            valve_cmd   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (!bus_cs) begin
                        bus_cs   <= 1'b1;
                        bus_rd   <= 1'b1;
                        bus_addr <= EC_ADDR;
                    end else if (bus_ready) begin
                        ec_value <= bus_rdata[15:0];
                        bus_cs   <= 1'b0;
                        bus_rd   <= 1'b0;
                        bus_addr <= '0;
                        state    <= ST_DECIDE;
                    end else if (tmo_expired) begin
                        timeout_err <= 1'b1;
                        bus_cs      <= 1'b0;
                        bus_rd      <= 1'b0;
                        bus_addr    <= '0;
                        period_cnt  <= PW'(PERIOD_CYCLES);
                        state       <= ST_WAIT;
                    end
                end
                ST_DECIDE: begin
                    valve_cmd <= next_cmd;
                    bus_cs    <= 1'b1;
                    bus_wr    <= 1'b1;
                    bus_addr  <= GPIO_ADDR;
                    bus_wdata <= {{(DATA_W-2){1'b0}}, next_cmd};
                    state     <= ST_WR;
                end
                ST_WR: begin
                    if (bus_ready || tmo_expired) begin
                        if (!bus_ready) begin
                            timeout_err <= 1'b1;
                        end
                        bus_cs     <= 1'b0;
                        bus_wr     <= 1'b0;
                        bus_addr   <= '0;
                        bus_wdata  <= '0;
                        period_cnt <= PW'(PERIOD_CYCLES);
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (period_cnt <= PW'(1)) begin
                        state <= ST_RD;
                    end else begin
                        period_cnt <= period_cnt - PW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irrigation_bus_master.sv
// Directed plus randomized bench for irrigation_bus_master with a simple bus peripheral model.
module tb_irrigation_bus_master;

    localparam int P       = 20;
    localparam int T       = 6;
    localparam int LOW_T   = 300;
    localparam int HIGH_T  = 600;
    localparam int ALARM_T = 900;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [4:0]  bus_addr;
    logic        bus_cs;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic [15:0] ec_value;
    logic [1:0]  valve_cmd;
    logic        busy;
    logic        timeout_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] rd_value = '0;
    int          rd_delay = 0;
    int          wr_delay = 0;
    bit          rd_never = 1'b0;
    int          cs_cnt = 0;
    int          n_writes = 0;
    logic [31:0] last_wdata = '0;
    int          bus_viol = 0;
    logic [1:0]  model_cmd = '0;
    int          last_ec = 0;
    int          last_start = 0;
    int          prev_extra = 0;

    irrigation_bus_master #(
        .PERIOD_CYCLES (P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus_addr   (bus_addr),
        .bus_cs     (bus_cs),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .ec_value   (ec_value),
        .valve_cmd  (valve_cmd),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Peripheral: ready after a programmable number of cycles with cs high.
    assign bus_rdata = {16'hA5A5, rd_value};
    assign bus_ready = bus_cs && !(bus_rd && rd_never) && (cs_cnt >= (bus_rd ? rd_delay : wr_delay));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        cs_cnt <= bus_cs ? cs_cnt + 1 : 0;
        if (bus_cs && bus_wr && bus_ready) begin
            n_writes   <= n_writes + 1;
            last_wdata <= bus_wdata;
        end
        if ((bus_rd && bus_wr) ||
            (!bus_cs && (bus_rd || bus_wr || (bus_addr != 5'd0) || (bus_wdata != 32'd0))))
            bus_viol <= bus_viol + 1;
    end

    function automatic logic [63:0] all_out();
        return 64'({bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata, ec_value, valve_cmd, busy, timeout_err});
    endfunction

    function automatic logic [1:0] model_next(input int ec, input logic [1:0] prev);
        logic valve;
        if (ec < LOW_T)       valve = 1'b1;
        else if (ec > HIGH_T) valve = 1'b0;
        else                  valve = prev[0];
        return {(ec >= ALARM_T), valve};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rd(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_rd) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle_bus();
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        check("busy_clear", 64'(busy), 64'd0);
    endtask

    task automatic do_poll(input int val, input int rdly, input int wdly,
                           input bit chk_gap, input bit drop_en, input string tag);
        bit ok;
        int rd_cyc;
        int w0;
        rd_value = 16'(val);
        rd_delay = rdly;
        wr_delay = wdly;
        w0 = n_writes;
        wait_rd(2 * P + 60, ok);
        check({tag, " rd_start"}, 64'(ok), 64'd1);
        if (drop_en) enable = 1'b0;
        if (chk_gap) check({tag, " gap"}, 64'(cyc - last_start), 64'(P + 4 + prev_extra));
        last_start = cyc;
        prev_extra = rdly + wdly;
        rd_cyc = 0;
        for (int i = 0; i < 50 && bus_rd; i++) begin
            rd_cyc++;
            @(negedge clk);
        end
        check({tag, " rd_len"}, 64'(rd_cyc), 64'(rdly + 1));
        wait_idle_bus();
        model_cmd = model_next(val, model_cmd);
        last_ec = val;
        check({tag, " ec"}, 64'(ec_value), 64'(val));
        check({tag, " valve"}, 64'(valve_cmd), 64'(model_cmd));
        check({tag, " writes"}, 64'(n_writes), 64'(w0 + 1));
        check({tag, " wdata"}, 64'(last_wdata), 64'(model_cmd));
    endtask

    initial begin
        bit ok;
        int nz;
        int w0;
        int rd_cyc;
        int bvals[7];

        // Reset and quiet idle
        repeat (3) @(negedge clk);
        check("in_reset", all_out(), 64'd0);
        rst = 1'b1;
        nz = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (all_out() != 64'd0) nz++;
        end
        check("idle_50", 64'(nz), 64'd0);

        // First poll, cycle-exact
        rd_value = 16'd250;
        rd_delay = 0;
        wr_delay = 0;
        enable = 1'b1;
        @(negedge clk);
        check("n0_busy", 64'({busy, bus_cs}), 64'b10);
        @(negedge clk);
        check("n1_rd", 64'({bus_cs, bus_rd, bus_wr, bus_addr}), 64'({3'b110, 5'h04}));
        last_start = cyc;
        prev_extra = 0;
        @(negedge clk);
        check("n2_ec", 64'({ec_value, bus_cs, busy}), 64'({16'd250, 2'b01}));
        @(negedge clk);
        check("n3_wr", 64'({bus_cs, bus_rd, bus_wr, bus_addr}), 64'({3'b101, 5'h00}));
        check("n3_wdata", 64'(bus_wdata), 64'h1);
        check("n3_valve", 64'(valve_cmd), 64'b01);
        @(negedge clk);
        check("n4_wait", 64'({busy, bus_cs}), 64'b00);
        check("n4_writes", 64'(n_writes), 64'd1);
        model_cmd = model_next(250, 2'b00);
        last_ec = 250;

        do_poll(450, 0, 0, 1, 0, "p450");
        do_poll(700, 0, 0, 1, 0, "p700");
        do_poll(950, 0, 0, 1, 0, "p950");
        check("seq_final", 64'(valve_cmd), 64'b10);

        bvals = '{299, 300, 600, 601, 899, 900, 300};
        foreach (bvals[k]) do_poll(bvals[k], 0, 0, 1, 0, "bound");

        do_poll(555, 3, 0, 1, 0, "rdly3");
        check("rdly3 tmo", 64'(timeout_err), 64'd0);
        do_poll(120, T - 1, T - 1, 1, 0, "edge_rdy");
        check("edge_rdy tmo", 64'(timeout_err), 64'd0);

        // Read that never completes
        rd_never = 1'b1;
        rd_value = 16'd77;
        w0 = n_writes;
        wait_rd(2 * P + 60, ok);
        check("tmo rd_start", 64'(ok), 64'd1);
        check("tmo gap", 64'(cyc - last_start), 64'(P + 4 + prev_extra));
        last_start = cyc;
        prev_extra = T - 3;
        rd_cyc = 0;
        for (int i = 0; i < 50 && bus_rd; i++) begin
            rd_cyc++;
            @(negedge clk);
        end
        check("tmo rd_len", 64'(rd_cyc), 64'(T));
        wait_idle_bus();
        check("tmo err", 64'(timeout_err), 64'd1);
        check("tmo no_wr", 64'(n_writes), 64'(w0));
        check("tmo valve", 64'(valve_cmd), 64'(model_cmd));
        check("tmo ec", 64'(ec_value), 64'(last_ec));
        rd_never = 1'b0;
        do_poll(350, 1, 0, 1, 0, "after_tmo");

        for (int k = 0; k < 8; k++)
            do_poll(int'($urandom_range(0, 1100)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1, 0, "rand");

        // enable dropped during a read: poll completes, then idle
        do_poll(400, 2, 1, 1, 1, "drop_rd");
        nz = 0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (bus_cs) nz++;
        end
        check("drop_rd idle", 64'(nz), 64'd0);

        rd_value = 16'd800;
        rd_delay = 0;
        wr_delay = 0;
        enable = 1'b1;
        @(negedge clk);
        check("reen n0", 64'(bus_cs), 64'd0);
        @(negedge clk);
        check("reen n1", 64'({bus_cs, bus_rd}), 64'b11);
        wait_idle_bus();
        model_cmd = model_next(800, model_cmd);
        check("reen valve", 64'(valve_cmd), 64'(model_cmd));

        // enable dropped in WAIT: back to IDLE at once
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("waitdrop n0", 64'(bus_cs), 64'd0);
        @(negedge clk);
        check("waitdrop n1", 64'({bus_cs, bus_rd}), 64'b11);
        wait_idle_bus();
        model_cmd = model_next(800, model_cmd);
        check("waitdrop valve", 64'(valve_cmd), 64'(model_cmd));

        // Async reset in the middle of a slow write
        rd_value = 16'd50;
        wr_delay = 5;
        ok = 1'b0;
        for (int i = 0; i < 2 * P + 60; i++) begin
            @(negedge clk);
            if (bus_wr) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_wr seen", 64'(ok), 64'd1);
        #2 rst = 1'b0;
        #1 check("rst_wr outs", all_out(), 64'd0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_cmd = 2'b00;
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (all_out() != 64'd0) nz++;
        end
        check("post_rst idle", 64'(nz), 64'd0);
        enable = 1'b1;
        do_poll(100, 0, 0, 0, 0, "post_rst");

        check("bus_rules", 64'(bus_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
